// File: rtl/param_memory.sv
// rtl/param_memory.sv - Word memory with byte-enabled core port, full-word loader port and sequential clear engine.
module param_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RD_REG = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     datain,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  memwe,
    input  logic [ADDR_W-1:0]     memaddr,
    input  logic [DATA_W-1:0]     memin,
    input  logic                  clr,
    output logic [DATA_W-1:0]     dataout,
    output logic                  busy,
    output logic                  collide
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   counter;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   be_mask;
    logic                clr_accept;
    logic                last_word;

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : g_mask
            assign be_mask[8*g +: 8] = {8{be[g]}};
        end
    endgenerate

    assign busy       = (state == CLEAR);
    assign clr_accept = (state == IDLE) && clr;
    assign last_word  = (counter == {ADDR_W{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clr) next_state = CLEAR;
            CLEAR:   if (last_word) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counter sits at zero in IDLE so entering CLEAR always starts at word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
        end else if (state == CLEAR) begin
            counter <= counter + 1'b1;
        end else begin
            counter <= '0;
        end
    end

    // One write per cycle: clear engine, then loader, then byte-masked core write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[counter] <= '0;
        end else if (memwe) begin
            mem[memaddr] <= memin;
        end else if (we) begin
            mem[address] <= (mem[address] & ~be_mask) | (datain & be_mask);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            collide <= 1'b0;
        end else if (clr_accept) begin
            collide <= 1'b0;
        end else if (!busy && we && memwe) begin
            collide <= 1'b1;
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd_q;
            // Samples the pre-edge contents, so a same-address write returns old data.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= mem[address];
                end
            end
            assign dataout = rd_q;
        end else begin : g_rd_comb
            assign dataout = mem[address];
        end
    endgenerate

endmodule

// File: tb/tb_param_memory.sv
// tb/tb_param_memory.sv - Directed table-driven bench for param_memory, combinational and registered read variants.
module tb_param_memory;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  address;
    logic [31:0] datain;
    logic [3:0]  be;
    logic        memwe;
    logic [4:0]  memaddr;
    logic [31:0] memin;
    logic        clr;
    logic [31:0] dout_c;
    logic [31:0] dout_r;
    logic        busy_c;
    logic        busy_r;
    logic        col_c;
    logic        col_r;

    int checks;
    int errors;

    param_memory #(.DATA_W(32), .ADDR_W(5), .RD_REG(0)) u_comb (
        .clk(clk), .reset(reset), .we(we), .address(address), .datain(datain), .be(be),
        .memwe(memwe), .memaddr(memaddr), .memin(memin), .clr(clr),
        .dataout(dout_c), .busy(busy_c), .collide(col_c)
    );

    param_memory #(.DATA_W(32), .ADDR_W(5), .RD_REG(1)) u_reg (
        .clk(clk), .reset(reset), .we(we), .address(address), .datain(datain), .be(be),
        .memwe(memwe), .memaddr(memaddr), .memin(memin), .clr(clr),
        .dataout(dout_r), .busy(busy_r), .collide(col_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        memwe;
        logic [4:0]  a;
        logic [31:0] din;
        logic [31:0] min;
        logic [3:0]  be;
        logic [31:0] exp;
        logic        ecol;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; memwe = 1'b0; clr = 1'b0; be = 4'h0;
        datain = '0; memin = '0; address = '0; memaddr = '0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 32; i++) begin
            memwe = 1'b1; memaddr = i[4:0]; memin = 32'h100 + i + 1;
            cyc();
        end
        memwe = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_inputs();

        vecs[0] = '{1'b0, 1'b1, 5'd3,  32'h0,        32'hDEADBEEF, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'd5,  32'h0,        32'h11223344, 4'h0, 32'h11223344, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 5'd5,  32'hAABBCCDD, 32'h0,        4'h5, 32'h11BB33DD, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 5'd5,  32'hFFFFFFFF, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 5'd0,  32'hCAFEF00D, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5'd31, 32'h12345678, 32'h0,        4'h8, 32'h12000000, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 5'd30, 32'h0,        32'hFFFFFFFF, 4'h0, 32'hFFFFFFFF, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 5'd7,  32'h00000001, 32'h00000002, 4'hF, 32'h00000002, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 5'd3,  32'h0000AB00, 32'h0,        4'h2, 32'hDEADABEF, 1'b1};

        #12;
        address = 5'd3;
        #1;
        chk("reset_dout_comb", dout_c, 32'h0);
        chk("reset_dout_reg", dout_r, 32'h0);
        chk("reset_busy", {31'h0, busy_c}, 32'h0);
        chk("reset_collide", {31'h0, col_c}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        for (int k = 0; k < 9; k++) begin
            we = vecs[k].we; memwe = vecs[k].memwe;
            address = vecs[k].a; memaddr = vecs[k].a;
            datain = vecs[k].din; memin = vecs[k].min; be = vecs[k].be;
            cyc();
            we = 1'b0; memwe = 1'b0; be = 4'h0;
            #1;
            chk($sformatf("vec%0d_dout_comb", k), dout_c, vecs[k].exp);
            chk($sformatf("vec%0d_collide", k), {31'h0, col_c}, {31'h0, vecs[k].ecol});
            cyc();
            chk($sformatf("vec%0d_dout_reg", k), dout_r, vecs[k].exp);
        end

        // Registered read returns old data when written in the same cycle.
        memwe = 1'b1; memaddr = 5'd2; memin = 32'd5;
        cyc();
        memwe = 1'b0;
        we = 1'b1; address = 5'd2; datain = 32'd9; be = 4'hF;
        cyc();
        we = 1'b0;
        chk("rdreg_old_data", dout_r, 32'd5);
        cyc();
        chk("rdreg_new_data", dout_r, 32'd9);

        // Full clear with drops, ignored re-clr and reads during the clear.
        fill_all();
        address = 5'd17;
        #1;
        chk("fill_word17", dout_c, 32'h112);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_drops_collide", {31'h0, col_c}, 32'h0);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_c) break;
            busy_cnt++;
            if (i == 3) begin
                address = 5'd2;
                #1;
                chk("clear_read_cleared", dout_c, 32'h0);
            end
            if (i == 5) begin
                address = 5'd20;
                #1;
                chk("clear_read_dropped", dout_c, 32'h115);
            end
            we    = (i == 4);
            memwe = (i == 4);
            clr   = (i == 10);
            if (i == 4) begin
                address = 5'd20; memaddr = 5'd20; be = 4'hF;
                datain = 32'hFFFFFFFF; memin = 32'hFFFFFFFF;
            end
            cyc();
            we = 1'b0; memwe = 1'b0; clr = 1'b0;
        end
        chk("clear_busy_cycles", busy_cnt, 32'd32);
        chk("clear_busy_reg", {31'h0, busy_r}, 32'h0);
        chk("clear_no_collide", {31'h0, col_c}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            address = i[4:0];
            #1;
            chk($sformatf("cleared_word%0d", i), dout_c, 32'h0);
        end

        // Reset mid-clear aborts asynchronously.
        fill_all();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        address = 5'd31;
        #1;
        chk("pre_reset_busy", {31'h0, busy_c}, 32'h1);
        chk("pre_reset_word31", dout_c, 32'h120);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_busy", {31'h0, busy_c}, 32'h0);
        chk("async_reset_word31", dout_c, 32'h0);
        chk("async_reset_dout_reg", dout_r, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        memwe = 1'b1; memaddr = 5'd9; memin = 32'h55;
        cyc();
        memwe = 1'b0;
        address = 5'd9;
        #1;
        chk("first_write_after_reset", dout_c, 32'h55);
        cyc();
        cyc();
        chk("post_reset_idle", {31'h0, busy_c}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            if (i == 9) continue;
            address = i[4:0];
            #1;
            chk($sformatf("post_reset_word%0d", i), dout_c, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth is 2**ADDR_W words.
REQ-003 The block SHALL have parameter RD_REG, default 0, read mode: 0 = combinational read, 1 = registered read.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 The block SHALL have port we, input, 1, core write enable.
REQ-007 The block SHALL have port address, input, ADDR_W, core read/write address.
REQ-008 The block SHALL have port datain, input, DATA_W, core write data.
REQ-009 The block SHALL have port be, input, DATA_W/8, core byte enables; bit i gates datain[8i+7:8i].
REQ-010 The block SHALL have port memwe, input, 1, loader write enable.
REQ-011 The block SHALL have port memaddr, input, ADDR_W, loader write address.
REQ-012 The block SHALL have port memin, input, DATA_W, loader write data, always full word.
REQ-013 The block SHALL have port clr, input, 1, one-cycle request to start a sequential clear.
REQ-014 The block SHALL have port dataout, output, DATA_W, read data for address.
REQ-015 The block SHALL have port busy, output, 1, high while a clear is in progress.
REQ-016 The block SHALL have port collide, output, 1, sticky flag: we and memwe were high in the same accepted cycle.

Function
REQ-017 Storage SHALL be 2**ADDR_W words of DATA_W bits.
REQ-018 Write priority SHALL be clear engine > memwe > we; only one write SHALL occur per cycle.
REQ-019 memwe=1 with busy=0 SHALL write memin to memaddr in full at the clock edge.
REQ-020 we=1, memwe=0, busy=0 SHALL write only the bytes of datain whose be bit is 1; other bytes SHALL keep their value.
REQ-021 we=1 with be all zero SHALL leave memory unchanged.
REQ-022 With RD_REG=0, dataout SHALL equal mem[address] combinationally; a write to that address is visible after the edge.
REQ-023 With RD_REG=1, dataout SHALL be registered mem[address] with one-cycle latency, read-before-write on same-address collision (old data).
REQ-024 The FSM SHALL have states IDLE and CLEAR.
REQ-025 IDLE -> CLEAR on clr=1; the clear counter SHALL load 0; busy SHALL rise on the next cycle.
REQ-026 In CLEAR, the block SHALL write 0 to mem[counter] each cycle and increment counter.
REQ-027 In CLEAR, when counter = 2**ADDR_W-1, the block SHALL write that word and return to IDLE; a clear SHALL take exactly 2**ADDR_W cycles with busy high.
REQ-028 clr while in CLEAR SHALL be ignored, with no restart.
REQ-029 we and memwe while busy=1 SHALL be dropped, not queued, and SHALL NOT set collide.
REQ-030 Reads while busy=1 SHALL operate normally; already-cleared words SHALL read 0.
REQ-031 collide SHALL set when we=1 and memwe=1 with busy=0, and stay set until reset or clr.
REQ-032 Address arithmetic SHALL be modulo 2**ADDR_W; no out-of-range access SHALL exist.

Reset
REQ-033 reset=0 SHALL immediately, without waiting for clk, force all memory words to 0, FSM to IDLE, counter to 0, busy=0, collide=0, and registered dataout (RD_REG=1) to 0.
REQ-034 reset asserted mid-clear SHALL abort the clear; after release, the FSM SHALL be in IDLE with all words 0.
REQ-035 After release, the first write SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-036 The bench SHALL cover: reset; memwe=1, memaddr=3, memin=0xDEADBEEF; read address=3 -> dataout=0xDEADBEEF (RD_REG=0 same cycle; RD_REG=1 next cycle).
REQ-037 The bench SHALL cover: mem[5]=0x11223344; we=1, be=4'b0101, datain=0xAABBCCDD at address 5 -> mem[5]=0x11BB33DD.
REQ-038 The bench SHALL cover: we=1, address=7, datain=1 and memwe=1, memaddr=7, memin=2 in the same cycle -> mem[7]=2, collide=1.
REQ-039 The bench SHALL cover: fill all 32 words, pulse clr -> busy high for exactly 32 cycles; we pulses during that time ignored; all words read 0 afterward.
REQ-040 The bench SHALL cover: reset=0 asserted at clear cycle 10 -> busy=0 asynchronously; after release, all words 0, FSM in IDLE.
REQ-041 The bench SHALL cover: RD_REG=1, mem[2]=5, we=1 with datain=9 at address 2 -> same-cycle read returns 5, next cycle returns 9.
